// File: rtl/fifo_sync_pkg.sv
// Shared constants and the checksum fold for the fifo_sync_blk_pipe family.
package fifo_sync_pkg;

  localparam int unsigned CHECKSUM_W     = 8;
  localparam int unsigned OUT_STAGES_MIN = 1;
  localparam int unsigned OUT_STAGES_MAX = 4;
  // Widest data word fold8 accepts; callers zero-extend to this width.
  localparam int unsigned FOLD_MAX_W     = 256;

  function automatic logic [CHECKSUM_W-1:0] fold8(input logic [FOLD_MAX_W-1:0] data);
    logic [CHECKSUM_W-1:0] f;
    f = '0;
    for (int i = 0; i < int'(FOLD_MAX_W / CHECKSUM_W); i++) begin
      f = f ^ data[i*CHECKSUM_W +: CHECKSUM_W];
    end
    return f;
  endfunction

endpackage

// File: rtl/fifo_sync_prefetch.sv
// First-word-fall-through register chain: compacted toward the head, loads bypass
// to the first free stage after this cycle's pop.
module fifo_sync_prefetch
  import fifo_sync_pkg::*;
#(
  parameter int unsigned Stages = 2,
  parameter int unsigned Width  = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_data_i,
  input  logic             pop_i,
  output logic             load_rdy_o,
  output logic [Width-1:0] head_o,
  output logic             head_valid_o,
  output logic [2:0]       occ_o
);

  logic [Width-1:0]  data_q [Stages];
  logic [Width-1:0]  data_d [Stages];
  logic [Width-1:0]  sh_data [Stages];
  logic [Stages-1:0] valid_q;
  logic [Stages-1:0] valid_d;
  logic [Stages-1:0] sh_valid;
  logic              placed;

  always_comb begin
    sh_data  = data_q;
    sh_valid = valid_q;
    if (pop_i) begin
      for (int i = 0; i < int'(Stages) - 1; i++) begin
        sh_data[i]  = data_q[i+1];
        sh_valid[i] = valid_q[i+1];
      end
      sh_valid[Stages-1] = 1'b0;
    end
  end

  assign load_rdy_o = ~sh_valid[Stages-1];

  always_comb begin
    data_d  = sh_data;
    valid_d = sh_valid;
    placed  = 1'b0;
    if (load_i) begin
      for (int i = 0; i < int'(Stages); i++) begin
        if (!placed && !sh_valid[i]) begin
          data_d[i]  = load_data_i;
          valid_d[i] = 1'b1;
          placed     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    occ_o = '0;
    for (int i = 0; i < int'(Stages); i++) begin
      occ_o = occ_o + 3'(valid_q[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign head_o       = data_q[0];
  assign head_valid_o = valid_q[0];

endmodule

// File: rtl/fifo_sync_blk_pipe.sv
// Single-clock block-RAM FIFO with optional input register and FWFT prefetch chain.
// Define FIFO_SYNC_CHECKSUM_EN to store and verify a running XOR fold with each word.
module fifo_sync_blk_pipe
  import fifo_sync_pkg::*;
#(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned INPUT_REG   = 1,
  parameter int unsigned OUT_STAGES  = 2,
  parameter int unsigned SIM_EMPTY_X = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_din,
  output logic              wr_full,
  output logic              wr_almostfull,
  input  logic [ADDR_W:0]   af_level,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_dout,
  output logic              rd_empty,
  output logic [ADDR_W:0]   count,
  output logic              wr_overflow,
  output logic              rd_underflow,
  output logic              checksum_error
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef FIFO_SYNC_CHECKSUM_EN
  localparam int unsigned RAM_W = DATA_W + CHECKSUM_W;
`else
  localparam int unsigned RAM_W = DATA_W;
`endif

  if (OUT_STAGES < OUT_STAGES_MIN || OUT_STAGES > OUT_STAGES_MAX) begin : g_bad_stages
    $error("fifo_sync_blk_pipe: OUT_STAGES must be in 1..4");
  end

  logic [ADDR_W:0] count_q, count_d;
  logic [ADDR_W:0] wr_ptr_q, rd_ptr_q;
  logic            ovf_q, unf_q;
  logic            wr_acc, rd_acc;
  logic            ram_we, ram_nonempty, rd_issue;
  logic            inflight_q, load_rdy, head_valid;
  logic [2:0]      occ;
  logic [RAM_W-1:0] wr_word, ram_wdata, ram_rdata_q, head_word;
  logic [RAM_W-1:0] mem_q [DEPTH];

  assign wr_full       = (count_q == (ADDR_W+1)'(DEPTH));
  assign wr_almostfull = ({1'b0, count_q} + {1'b0, af_level}) >= (ADDR_W+2)'(DEPTH);
  assign rd_empty      = ~head_valid;
  assign wr_acc        = wr_en & ~wr_full;
  assign rd_acc        = rd_en & head_valid;
  assign count         = count_q;
  assign wr_overflow   = ovf_q;
  assign rd_underflow  = unf_q;

  always_comb begin
    count_d = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_q | (wr_en & wr_full);
      unf_q   <= unf_q | (rd_en & ~head_valid);
    end
  end

`ifdef FIFO_SYNC_CHECKSUM_EN
  logic [CHECKSUM_W-1:0] wr_fold_q, rd_fold_q;
  logic                  cerr_q;

  // Each word carries the fold of everything written before it.
  assign wr_word        = {wr_fold_q, wr_din};
  assign checksum_error = cerr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_fold_q <= '0;
      rd_fold_q <= '0;
      cerr_q    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_fold_q <= wr_fold_q ^ fold8(FOLD_MAX_W'(wr_din));
      end
      if (rd_acc) begin
        rd_fold_q <= rd_fold_q ^ fold8(FOLD_MAX_W'(head_word[DATA_W-1:0]));
        if (head_word[RAM_W-1:DATA_W] != rd_fold_q) begin
          cerr_q <= 1'b1;
        end
      end
    end
  end
`else
  assign wr_word        = wr_din;
  assign checksum_error = 1'b0;
`endif

  if (INPUT_REG != 0) begin : g_in_reg
    logic             in_vld_q;
    logic [RAM_W-1:0] in_word_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        in_vld_q <= 1'b0;
      end else begin
        in_vld_q <= wr_acc;
      end
    end

    always_ff @(posedge clk) begin
      if (wr_acc) begin
        in_word_q <= wr_word;
      end
    end

    assign ram_we    = in_vld_q;
    assign ram_wdata = in_word_q;
  end else begin : g_in_direct
    assign ram_we    = wr_acc;
    assign ram_wdata = wr_word;
  end

  // The RAM output register is a holding slot, so one read may be outstanding while
  // the chain is full minus one; this keeps OUT_STAGES>=2 bubble-free without rd_en.
  assign ram_nonempty = (wr_ptr_q != rd_ptr_q);
  assign rd_issue     = ram_nonempty &
                        ((4'(occ) + 4'(inflight_q)) <= 4'(OUT_STAGES));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      if (ram_we) begin
        wr_ptr_q <= wr_ptr_q + (ADDR_W+1)'(1);
      end
      if (rd_issue) begin
        rd_ptr_q <= rd_ptr_q + (ADDR_W+1)'(1);
      end
      inflight_q <= rd_issue | (inflight_q & ~load_rdy);
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= ram_wdata;
    end
    if (rd_issue) begin
      ram_rdata_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
    end
  end

  fifo_sync_prefetch #(
    .Stages(OUT_STAGES),
    .Width (RAM_W)
  ) u_prefetch (
    .clk_i       (clk),
    .reset_i     (reset),
    .load_i      (inflight_q),
    .load_data_i (ram_rdata_q),
    .pop_i       (rd_acc),
    .load_rdy_o  (load_rdy),
    .head_o      (head_word),
    .head_valid_o(head_valid),
    .occ_o       (occ)
  );

  assign rd_dout = ((SIM_EMPTY_X != 0) && rd_empty) ? {DATA_W{1'bx}} : head_word[DATA_W-1:0];

endmodule

// File: tb/tb_fifo_sync_blk_pipe.sv
// Self-checking bench for fifo_sync_blk_pipe with a data scoreboard and occupancy model.
module tb_fifo_sync_blk_pipe;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int          DEPTH  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] wr_din, rd_dout;
  logic [ADDR_W:0]   af_level, count;
  logic              wr_full, wr_almostfull, rd_empty;
  logic              wr_overflow, rd_underflow, checksum_error;

  always #5 clk = ~clk;

  fifo_sync_blk_pipe #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .INPUT_REG  (1),
    .OUT_STAGES (2),
    .SIM_EMPTY_X(0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_din        (wr_din),
    .wr_full       (wr_full),
    .wr_almostfull (wr_almostfull),
    .af_level      (af_level),
    .rd_en         (rd_en),
    .rd_dout       (rd_dout),
    .rd_empty      (rd_empty),
    .count         (count),
    .wr_overflow   (wr_overflow),
    .rd_underflow  (rd_underflow),
    .checksum_error(checksum_error)
  );

  typedef struct {
    logic        we;
    logic [31:0] din;
    logic        re;
    int          exp_count;
    logic        exp_empty;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_count;
  logic        m_ovf, m_unf, m_cerr;
  int          pop_no;
  int          corrupt_pop;
  logic [31:0] sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 64'(count), 64'(m_count));
    chk("wr_full", 64'(wr_full), 64'(m_count == DEPTH));
    chk("wr_almostfull", 64'(wr_almostfull), 64'((m_count + int'(af_level)) >= DEPTH));
    chk("wr_overflow", 64'(wr_overflow), 64'(m_ovf));
    chk("rd_underflow", 64'(rd_underflow), 64'(m_unf));
    chk("checksum_error", 64'(checksum_error), 64'(m_cerr));
  endtask

  // Drive one cycle; inputs are applied #1 after the previous rising edge.
  task automatic cycle(input logic we, input logic [31:0] din, input logic re);
    logic        w_acc, r_acc;
    logic [31:0] exp;
    wr_en  = we;
    wr_din = din;
    rd_en  = re;
    w_acc  = we && (m_count != DEPTH);
    r_acc  = re && !rd_empty;
    if (we && m_count == DEPTH) m_ovf = 1'b1;
    if (re && rd_empty) m_unf = 1'b1;
    if (r_acc) begin
      if (sb.size() == 0) begin
        chk("pop_with_no_data", 64'(1), 64'(0));
      end else begin
        exp = sb.pop_front();
        chk("rd_dout", 64'(rd_dout), 64'(exp));
      end
      if (pop_no == corrupt_pop) m_cerr = 1'b1;
      pop_no++;
    end
    if (w_acc) sb.push_back(din);
    m_count = m_count + int'(w_acc) - int'(r_acc);
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    m_count = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_cerr = 1'b0;
    pop_no = 0;
    corrupt_pop = -1;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(rd_empty), 64'(1));
    chk("rst_full", 64'(wr_full), 64'(0));
    chk("rst_almostfull", 64'(wr_almostfull), 64'(int'(af_level) >= DEPTH));
    chk("rst_flags", 64'({wr_overflow, rd_underflow, checksum_error}), 64'(0));
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (rd_empty && n < 20) begin
      cycle(1'b0, 32'h0, 1'b0);
      n++;
    end
    chk(name, 64'(rd_empty), 64'(0));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      cycle(1'b0, 32'h0, 1'b1);
      n++;
    end
    chk({name, "_left"}, 64'(sb.size()), 64'(0));
    cycle(1'b0, 32'h0, 1'b0);
    chk({name, "_empty"}, 64'(rd_empty), 64'(1));
    chk({name, "_count"}, 64'(count), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    reset    = 1'b1;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    wr_din   = '0;
    af_level = '0;
    m_count  = 0;
    pop_no   = 0;
    corrupt_pop = -1;
    @(posedge clk);
    do_reset();

    // 1: single-word latency, head visible in cycle 4.
    vt[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1, 1'b1};
    vt[1] = '{1'b0, 32'h0,         1'b0, 1, 1'b1};
    vt[2] = '{1'b0, 32'h0,         1'b0, 1, 1'b1};
    vt[3] = '{1'b0, 32'h0,         1'b0, 1, 1'b0};
    vt[4] = '{1'b0, 32'h0,         1'b1, 0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("t1_dout", 64'(rd_dout), 64'(32'hA5A5_0001));
      cycle(vt[i].we, vt[i].din, vt[i].re);
      chk("t1_count", 64'(count), 64'(vt[i].exp_count));
      chk("t1_empty", 64'(rd_empty), 64'(vt[i].exp_empty));
    end

    // 2: fill past capacity, then read back in order.
    do_reset();
    for (int i = 0; i < 33; i++) cycle(1'b1, 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0);
    chk("t2_full", 64'(wr_full), 64'(1));
    chk("t2_count", 64'(count), 64'(32));
    chk("t2_overflow", 64'(wr_overflow), 64'(1));
    drain("t2");

    // 3: streaming, one word per cycle after priming.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 32'h1000 + 32'(i), 1'b1);
      if (i >= 10) begin
        chk("t3_no_bubble", 64'(rd_empty), 64'(0));
        chk("t3_count_const", 64'(count), 64'(4));
      end
    end
    drain("t3");

    // 4: underflow is sticky and harmless.
    do_reset();
    cycle(1'b0, 32'h0, 1'b1);
    chk("t4_underflow", 64'(rd_underflow), 64'(1));
    chk("t4_count", 64'(count), 64'(0));
    cycle(1'b1, 32'h55, 1'b0);
    wait_ready("t4_ready");
    cycle(1'b0, 32'h0, 1'b1);
    chk("t4_underflow_sticky", 64'(rd_underflow), 64'(1));

    // 5: reset mid-operation discards everything in flight.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'hBEEF_0000 + 32'(i), 1'b0);
    do_reset();
    cycle(1'b1, 32'h1, 1'b0);
    wait_ready("t5_ready");
    chk("t5_first", 64'(rd_dout), 64'(1));
    cycle(1'b0, 32'h0, 1'b1);

    // 6: almost-full threshold, then write+read while full.
    af_level = 6'd4;
    do_reset();
    for (int i = 0; i < 27; i++) cycle(1'b1, 32'h600 + 32'(i), 1'b0);
    chk("t6_af_at27", 64'(wr_almostfull), 64'(0));
    cycle(1'b1, 32'h600 + 32'd27, 1'b0);
    chk("t6_af_at28", 64'(wr_almostfull), 64'(1));
    for (int i = 28; i < 32; i++) cycle(1'b1, 32'h600 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'hDEAD, 1'b1);
    chk("t6_full_wr_rd_count", 64'(count), 64'(31));
    chk("t6_full_wr_rd_ovf", 64'(wr_overflow), 64'(1));
    drain("t6");
    af_level = 6'd32;
    do_reset();
    af_level = 6'd0;
    cycle(1'b0, 32'h0, 1'b0);

`ifdef FIFO_SYNC_CHECKSUM_EN
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h1234_5600 + 32'(i), 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0);
    dut.mem_q[6][DATA_W +: 8] = dut.mem_q[6][DATA_W +: 8] ^ 8'hFF;
    corrupt_pop = 6;
    drain("tc");
    chk("tc_checksum_error", 64'(checksum_error), 64'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
